// File: rtl/bit_scan_pkg.sv
// Shared constants and state encoding for the bit_scan_seq set-bit enumerator.
package bit_scan_pkg;

    localparam int WORD = 16;
    localparam int IDX  = 4;
    localparam int CNT  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/bit_scan_seq_msb_index.sv
// msb_index: combinational priority encoder giving the highest set bit of a word
// and whether exactly one bit is set.
module msb_index
    import bit_scan_pkg::*;
(
    input  logic [WORD-1:0] i_rem,
    output logic [IDX-1:0]  o_index,
    output logic            o_one_left
);

    // Later (higher) set bits overwrite earlier ones, so the MSB wins.
    always_comb begin
        o_index = {IDX{1'b0}};
        for (int i = 0; i < WORD; i++) begin
            if (i_rem[i]) begin
                o_index = IDX'(i);
            end else begin
                o_index = o_index;
            end
        end
    end

    // Power-of-two test: clearing the lowest set bit leaves nothing.
    always_comb begin
        o_one_left = (i_rem != {WORD{1'b0}}) &&
                     ((i_rem & (i_rem - {{(WORD-1){1'b0}}, 1'b1})) == {WORD{1'b0}});
    end

endmodule

// File: rtl/bit_scan_seq.sv
// bit_scan_seq: emits the index of every set bit of a 16-bit word, MSB first.
// Optional out_count port and set-bit counter are enabled by BITSCAN_COUNT_EN.
module bit_scan_seq
    import bit_scan_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WORD-1:0] in_word,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDX-1:0]  out_index,
    output logic            out_last,
    output logic            out_none
`ifdef BITSCAN_COUNT_EN
   ,output logic [CNT-1:0]  out_count
`endif
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [WORD-1:0] r_rem;
    logic [WORD-1:0] w_rem_nxt;
    logic [IDX-1:0]  w_msb_idx;
    logic            w_one_left;
    logic            w_rem_zero;
    logic            w_scan;
    logic            w_handshake;

    msb_index u_msb_index (
        .i_rem      (r_rem),
        .o_index    (w_msb_idx),
        .o_one_left (w_one_left)
    );

    assign w_scan      = (r_state == SCAN);
    assign w_rem_zero  = (r_rem == {WORD{1'b0}});
    assign w_handshake = w_scan & out_ready;

    // State and remaining-mask registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_rem   <= {WORD{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Next state: accept in IDLE, leave SCAN on the handshake of the last beat.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_nxt = SCAN;
                    w_rem_nxt   = in_word;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    w_rem_nxt = r_rem & ~({{(WORD-1){1'b0}}, 1'b1} << w_msb_idx);
                    if (w_one_left || w_rem_zero) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = SCAN;
                    end
                end else begin
                    w_state_nxt = SCAN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_rem_nxt   = {WORD{1'b0}};
            end
        endcase
    end

    // Outputs are decoded from registered state, so they hold through stalls.
    always_comb begin
        in_ready  = ~w_scan;
        out_valid = w_scan;
        if (w_scan) begin
            out_index = w_msb_idx;
            out_last  = w_one_left | w_rem_zero;
            out_none  = w_rem_zero;
        end else begin
            out_index = {IDX{1'b0}};
            out_last  = 1'b0;
            out_none  = 1'b0;
        end
    end

`ifdef BITSCAN_COUNT_EN
    logic [CNT-1:0] r_cnt;

    // Handshake counter; 5 bits so a full word reports 16 without wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= {CNT{1'b0}};
        end else if (r_state == IDLE && in_valid) begin
            r_cnt <= {CNT{1'b0}};
        end else if (w_handshake) begin
            r_cnt <= r_cnt + {{(CNT-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // The last beat counts itself; a zero word reports 0.
    always_comb begin
        if (w_scan && w_one_left) begin
            out_count = r_cnt + {{(CNT-1){1'b0}}, 1'b1};
        end else begin
            out_count = {CNT{1'b0}};
        end
    end
`endif

endmodule

// File: doc/bit_scan_seq.md
# bit_scan_seq

Sequential set-bit enumerator. Accepts a 16-bit word and emits the bit index of every set bit, most significant first, one index per cycle over a valid/ready stream. It is the consumer-side counterpart of the team's one-hot MSB isolation and popcount logic: those reduce a word to a one-hot or a count, and this block expands a word back into the positions of its set bits. Used by the datapath for multi-register operations that walk a register mask.

## Interface
Parameters:
- None. Widths are fixed by package constants: WORD = 16, IDX = 4.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  in_word is valid
- in_ready  output  1  block can accept a word (high only in IDLE)
- in_word  input  16  mask to scan
- out_valid  output  1  out_index/out_last/out_none are valid
- out_ready  input  1  consumer accepts the current beat
- out_index  output  4  bit position of the current set bit
- out_last  output  1  current beat is the final beat for this word
- out_none  output  1  the word was zero; single dummy beat
- out_count  output  5  set-bit total, valid on the last beat (present only with BITSCAN_COUNT_EN)

## Operation
- States: IDLE, SCAN.
- IDLE: in_ready=1. On in_valid, latch in_word into rem, clear cnt, go to SCAN.
- SCAN: out_valid=1. out_index = position of the highest set bit of rem. out_last = 1 when rem has exactly one set bit, or rem==0.
- On an out handshake (out_valid & out_ready): clear bit out_index in rem and increment cnt. If out_last, go to IDLE.
- Zero word: one beat with out_index=0, out_none=1, out_last=1, out_count=0.
- Stall (out_ready=0): rem, out_index, out_last and out_none are held stable. out_valid is never dropped once asserted.
- in_valid asserted in SCAN is ignored, because in_ready=0. The word is not lost on the source side; it stays pending.
- cnt is 5 bits wide, so 16 set bits gives out_count=16 with no overflow.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_index=0, out_last=0, out_none=0, out_count=0, rem=0.
- Latency: a word accepted at edge t gives its first beat valid after edge t (cycle t+1).
- Throughput: one index per cycle while out_ready=1. A word with N set bits occupies N cycles in SCAN (1 cycle if the word is zero).
- Recovery: after the last handshake there is one IDLE cycle before the next word is accepted. Worst-case period is N+1 cycles.
- Reset asserted mid-scan: immediate return to reset values. The in-flight word is discarded and no further beats are emitted.

## Configuration
- BITSCAN_COUNT_EN defined:
  - out_count port and the cnt register exist.
  - out_count = total set bits on the last beat, and 0 on all other beats.
- Not defined:
  - Port and register are absent.
  - All other behaviour is identical.

## Structure
- Shared package bit_scan_pkg:
  - WORD=16, IDX=4, CNT=5.
  - State enum: IDLE=1'b0, SCAN=1'b1.
- Sub-module msb_index: combinational 16→4 priority encoder.
  - Outputs: highest set bit index, plus a one_left flag (exactly one bit set).
  - The one_left flag is computed as rem & (rem-1) == 0 with rem != 0.
- The top module holds only the FSM, rem, cnt and the handshake logic.

## Test plan
- in_word=16'h8001, out_ready=1 → beats: index 15 (last=0), then index 0 (last=1). in_ready is high again 3 cycles after acceptance.
- in_word=16'h0000 → single beat: index=0, none=1, last=1. With BITSCAN_COUNT_EN, out_count=0.
- in_word=16'hFFFF, out_ready toggling 1/0 every cycle → 16 beats, indices 15..0. Outputs are stable through every stall, and last=1 only on index 0.
- in_word=16'h00F0; assert reset after the beats for 7 and 6 → the next cycle has out_valid=0 and in_ready=1. Indices 5 and 4 are never emitted.
- Two words back-to-back (16'h0003, then 16'h0400 held on in_valid) → in_ready=0 during the first scan. The second word is accepted in the IDLE cycle after index 0, giving the single beat index=10, last=1.
- BITSCAN_COUNT_EN, in_word=16'h0F0F → 8 beats (11,10,9,8,3,2,1,0), with out_count=8 on the last beat only.
